// File: rtl/nlprg_pkg.sv
// Shared definitions for the PRNG word scheduler: FSM encoding and default sizes.
package nlprg_pkg;

    localparam int NLPRG_N_DEF    = 4;
    localparam int NLPRG_NREQ_DEF = 4;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/nlprg_rr_arb.sv
// Combinational round-robin arbiter: picks the first requester above last_granted.
module nlprg_rr_arb
    import nlprg_pkg::*;
#(
    parameter int NREQ = NLPRG_NREQ_DEF,
    parameter int LGW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [LGW-1:0]  last_granted,
    output logic [NREQ-1:0] winner
);

    logic [LGW-1:0] idx;

    // Walk the search order from farthest to nearest so the nearest requester is written last.
    always_comb begin
        // NOTE: every combinational output gets a default first; a path that leaves it unassigned infers a latch.
        winner = '0;
        idx    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = LGW'((int'(last_granted) + k) % NREQ);
            if (req[idx]) begin
                winner = {{(NREQ-1){1'b0}}, 1'b1} << idx;
            end
        end
    end

endmodule

// File: rtl/nlprg_sched.sv
// Hands out words of an external PRNG to round-robin requesters, one word per cycle,
// while checking that the PRNG returns to its start value after exactly 2^N steps.
module nlprg_sched
    import nlprg_pkg::*;
#(
    parameter int N    = NLPRG_N_DEF,
    parameter int NREQ = NLPRG_NREQ_DEF
) (
    input  logic            ck,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [N-1:0]    rnd,
    output logic            rnd_vld,
    output logic            prng_en,
    input  logic [N-1:0]    prng_o,
    output logic            period_ok,
    output logic            period_err
);

    localparam int       LGW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [N:0] PERIOD = {1'b1, {N{1'b0}}};

    state_e          state_q, state_d;
    logic [N-1:0]    start_val_q, start_val_d;
    logic [N:0]      scnt_q, scnt_d;
    logic [LGW-1:0]  last_granted_q, last_granted_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [N-1:0]    rnd_q, rnd_d;
    logic            rnd_vld_q, rnd_vld_d;
    logic            period_ok_q, period_ok_d;
    logic            period_err_q, period_err_d;

    logic [NREQ-1:0] winner;
    logic [LGW-1:0]  win_idx;
    logic            checking;

    nlprg_rr_arb #(
        .NREQ (NREQ),
        .LGW  (LGW)
    ) u_arb (
        .req          (req),
        .last_granted (last_granted_q),
        .winner       (winner)
    );

    // The PRNG steps on exactly the edges where a word is handed out.
    assign prng_en = (state_q == S_RUN) && (|req);

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner[i]) begin
                win_idx = LGW'(i);
            end
        end
    end

    assign checking = !period_ok_q && !period_err_q && (scnt_q != '0);

    always_comb begin
        // NOTE: combinational logic uses blocking '=' so later statements see the updated value.
        state_d        = state_q;
        start_val_d    = start_val_q;
        scnt_d         = scnt_q;
        last_granted_d = last_granted_q;
        gnt_d          = '0;
        rnd_d          = rnd_q;
        rnd_vld_d      = 1'b0;
        period_ok_d    = period_ok_q;
        period_err_d   = period_err_q;

        case (state_q)
            S_INIT: begin
                start_val_d = prng_o;
                state_d     = S_RUN;
            end
            S_RUN: begin
                if (|req) begin
                    gnt_d          = winner;
                    rnd_d          = prng_o;
                    rnd_vld_d      = 1'b1;
                    last_granted_d = win_idx;
                end
                if (prng_en && !period_ok_q && !period_err_q && (scnt_q != PERIOD)) begin
                    scnt_d = scnt_q + 1'b1;
                end
                // Back at the start value: good only if exactly a full period elapsed.
                if (checking) begin
                    if (prng_o == start_val_q) begin
                        if (scnt_q == PERIOD) begin
                            period_ok_d = 1'b1;
                        end else begin
                            period_err_d = 1'b1;
                        end
                    end else if (scnt_q == PERIOD) begin
                        period_err_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge ck or negedge rst_n) begin
        // NOTE: every flop here is small control state, so all get an async reset value; sequential logic uses '<='.
        if (!rst_n) begin
            state_q        <= S_INIT;
            start_val_q    <= '0;
            scnt_q         <= '0;
            last_granted_q <= LGW'(NREQ - 1);
            gnt_q          <= '0;
            rnd_q          <= '0;
            rnd_vld_q      <= 1'b0;
            period_ok_q    <= 1'b0;
            period_err_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_val_q    <= start_val_d;
            scnt_q         <= scnt_d;
            last_granted_q <= last_granted_d;
            gnt_q          <= gnt_d;
            rnd_q          <= rnd_d;
            rnd_vld_q      <= rnd_vld_d;
            period_ok_q    <= period_ok_d;
            period_err_q   <= period_err_d;
        end
    end

    assign gnt        = gnt_q;
    assign rnd        = rnd_q;
    assign rnd_vld    = rnd_vld_q;
    assign period_ok  = period_ok_q;
    assign period_err = period_err_q;

endmodule

// File: tb/tb_nlprg_sched.sv
// Bench for nlprg_sched: stub counter PRNG, a per-cycle reference model and directed scenarios.
module tb_nlprg_sched;

    localparam int N      = 4;
    localparam int NREQ   = 4;
    localparam int PERIOD = 1 << N;

    logic            ck;
    logic            rst_n;
    logic            stub_rst_n;
    logic            wrap8;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [N-1:0]    rnd;
    logic            rnd_vld;
    logic            prng_en;
    logic [N-1:0]    prng_o;
    logic            period_ok;
    logic            period_err;

    int n_checks = 0;
    int n_errors = 0;

    nlprg_sched #(
        .N    (N),
        .NREQ (NREQ)
    ) dut (
        .ck         (ck),
        .rst_n      (rst_n),
        .req        (req),
        .gnt        (gnt),
        .rnd        (rnd),
        .rnd_vld    (rnd_vld),
        .prng_en    (prng_en),
        .prng_o     (prng_o),
        .period_ok  (period_ok),
        .period_err (period_err)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Stub PRNG: up-counter, optionally wrapping modulo 8 to fake a short period.
    always_ff @(posedge ck or negedge stub_rst_n) begin
        if (!stub_rst_n) begin
            prng_o <= '0;
        end else if (prng_en) begin
            prng_o <= wrap8 ? ((prng_o + 4'd1) & 4'd7) : (prng_o + 4'd1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (((r >> ((last + k) % NREQ)) & 4'b0001) != 0) return (last + k) % NREQ;
        end
        return 0;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        return 4'b0001 << i;
    endfunction

    // Reference model
    logic            m_run;
    int              m_last;
    logic [N-1:0]    m_start;
    int              m_steps;
    logic            m_ok, m_err;
    logic [NREQ-1:0] e_gnt;
    logic [N-1:0]    e_rnd;
    logic            e_vld;

    always @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            m_run   <= 1'b0;
            m_last  <= NREQ - 1;
            m_start <= '0;
            m_steps <= 0;
            m_ok    <= 1'b0;
            m_err   <= 1'b0;
            e_gnt   <= '0;
            e_rnd   <= '0;
            e_vld   <= 1'b0;
        end else if (!m_run) begin
            m_run   <= 1'b1;
            m_start <= prng_o;
        end else begin
            if (req != '0) begin
                e_gnt  <= onehot(rr_pick(req, m_last));
                m_last <= rr_pick(req, m_last);
                e_rnd  <= prng_o;
                e_vld  <= 1'b1;
                if (!m_ok && !m_err && m_steps < PERIOD) m_steps <= m_steps + 1;
            end else begin
                e_gnt <= '0;
                e_vld <= 1'b0;
            end
            if (!m_ok && !m_err && m_steps != 0) begin
                if (prng_o == m_start) begin
                    if (m_steps == PERIOD) m_ok <= 1'b1;
                    else                   m_err <= 1'b1;
                end else if (m_steps == PERIOD) begin
                    m_err <= 1'b1;
                end
            end
        end
    end

    always @(negedge ck) begin
        check("gnt",        32'(gnt),        32'(e_gnt));
        check("rnd",        32'(rnd),        32'(e_rnd));
        check("rnd_vld",    32'(rnd_vld),    32'(e_vld));
        check("prng_en",    32'(prng_en),    32'(m_run && (req != '0)));
        check("period_ok",  32'(period_ok),  32'(m_ok));
        check("period_err", 32'(period_err), 32'(m_err));
    end

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    // Leaves the DUT in S_RUN with start_val captured and the stub at 0.
    task automatic do_reset(input logic w8);
        rst_n      = 1'b0;
        stub_rst_n = 1'b0;
        wrap8      = w8;
        req        = '0;
        tick();
        tick();
        rst_n      = 1'b1;
        stub_rst_n = 1'b1;
        tick();
    endtask

    logic [NREQ-1:0] seq_all [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [NREQ-1:0] seq_odd [4] = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        stub_rst_n = 1'b0;
        wrap8      = 1'b0;
        req        = 4'b1111;

        // Reset holds everything quiet even with all requesters active.
        tick();
        tick();
        check("rst_gnt",     32'(gnt),        0);
        check("rst_vld",     32'(rnd_vld),    0);
        check("rst_prng_en", 32'(prng_en),    0);
        check("rst_ok",      32'(period_ok),  0);
        check("rst_err",     32'(period_err), 0);
        rst_n      = 1'b1;
        stub_rst_n = 1'b1;
        #2;
        check("init_prng_en", 32'(prng_en), 0);
        tick();
        req = 4'b0001;

        // Single requester: three consecutive words 0,1,2.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("single_gnt", 32'(gnt), 32'h1);
            check("single_rnd", 32'(rnd), 32'(i));
        end
        req = '0;
        tick();
        check("single_drop_gnt", 32'(gnt),     0);
        check("single_drop_vld", 32'(rnd_vld), 0);
        check("single_hold_rnd", 32'(rnd),     32'h2);

        // Round-robin over all four, then over requesters 0 and 2.
        do_reset(1'b0);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_all_gnt", 32'(gnt), 32'(seq_all[i]));
            check("rr_all_rnd", 32'(rnd), 32'(i));
        end
        req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_odd_gnt", 32'(gnt), 32'(seq_odd[i]));
        end
        req = '0;
        tick();

        // A request pulse between edges drives prng_en only; no grant, no PRNG step.
        #1 req = 4'b0010;
        #1 check("glitch_prng_en_hi", 32'(prng_en), 1);
        req = '0;
        #1 check("glitch_prng_en_lo", 32'(prng_en), 0);
        tick();
        check("glitch_no_gnt", 32'(gnt), 0);
        req = 4'b0010;
        tick();
        check("post_glitch_gnt", 32'(gnt), 32'h2);
        check("post_glitch_rnd", 32'(rnd), 32'h9);
        req = '0;
        tick();

        // Full period: 16 steps bring the counter back to its start value.
        do_reset(1'b0);
        req = 4'b0001;
        for (int i = 0; i < PERIOD; i++) tick();
        req = '0;
        check("full_ok_early", 32'(period_ok), 0);
        tick();
        check("full_ok",  32'(period_ok),  1);
        check("full_err", 32'(period_err), 0);
        tick();
        tick();
        check("full_ok_sticky", 32'(period_ok), 1);

        // Short period: counter wraps after 8 steps.
        do_reset(1'b1);
        req = 4'b0001;
        for (int i = 0; i < 8; i++) tick();
        req = '0;
        check("short_err_early", 32'(period_err), 0);
        tick();
        check("short_err", 32'(period_err), 1);
        check("short_ok",  32'(period_ok),  0);
        req = 4'b0001;
        for (int i = 0; i < 3; i++) tick();
        req = '0;
        check("short_err_sticky", 32'(period_err), 1);
        check("short_ok_sticky",  32'(period_ok),  0);
        tick();

        // Mid-operation reset: outputs clear without a clock, then start_val is re-captured.
        do_reset(1'b0);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) tick();
        #1 rst_n = 1'b0;
        #1;
        check("midrst_gnt",     32'(gnt),        0);
        check("midrst_rnd",     32'(rnd),        0);
        check("midrst_vld",     32'(rnd_vld),    0);
        check("midrst_prng_en", 32'(prng_en),    0);
        check("midrst_ok",      32'(period_ok),  0);
        check("midrst_err",     32'(period_err), 0);
        tick();
        tick();
        rst_n = 1'b1;
        req   = '0;
        tick();
        req = 4'b0001;
        tick();
        check("midrst_first_rnd", 32'(rnd), 32'h5);
        for (int i = 1; i < PERIOD; i++) tick();
        req = '0;
        tick();
        check("midrst_full_ok",  32'(period_ok),  1);
        check("midrst_full_err", 32'(period_err), 0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nlprg_sched.md
NLPRG_SCHED -- requirements
Module: nlprg_sched

Interface
REQ-001 SHALL have parameter N, default 4, PRNG word width.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters.
REQ-003 SHALL have port ck  input  1  sole clock, all state on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  NREQ  per-requester random-word request, level.
REQ-006 SHALL have port gnt  output  NREQ  one-hot grant, one-cycle pulse per delivered word.
REQ-007 SHALL have port rnd  output  N  random word delivered with gnt.
REQ-008 SHALL have port rnd_vld  output  1  high in every cycle gnt is non-zero.
REQ-009 SHALL have port prng_en  output  1  step enable to the external PRNG; PRNG advances on the posedge where it is high.
REQ-010 SHALL have port prng_o  input  N  current external PRNG output.
REQ-011 SHALL have port period_ok  output  1  sticky, full period 2^N confirmed.
REQ-012 SHALL have port period_err  output  1  sticky, wrong period detected.

Function
REQ-013 SHALL implement FSM S_INIT -> S_RUN; S_INIT lasts exactly one cycle after rst_n deasserts, captures prng_o into start_val, and holds prng_en=0.
REQ-014 In S_RUN, prng_en SHALL equal the combinational OR of req (no registering).
REQ-015 On each posedge in S_RUN with |req, gnt SHALL register the one-hot round-robin winner, rnd SHALL register the pre-step prng_o, and rnd_vld SHALL register 1; otherwise gnt=0 and rnd_vld=0, with rnd holding its last value.
REQ-016 Latency SHALL be one cycle from req sample to gnt/rnd; throughput SHALL be one word per cycle; each PRNG value SHALL be delivered to exactly one requester.
REQ-017 Round-robin SHALL search from (last_granted+1) mod NREQ upward; last_granted SHALL update only on a grant; the reset value of last_granted SHALL be NREQ-1 so that req[0] wins first.
REQ-018 A requester that holds req after gnt SHALL compete again on the next cycle, with no priority boost.
REQ-019 Step counter scnt (N+1 bits) SHALL increment on every prng_en step and saturate at 2^N; it SHALL stop counting once period_ok or period_err is set.
REQ-020 The period check SHALL be evaluated each S_RUN cycle while both flags are 0 and scnt is non-zero; the first matching condition applies.
REQ-021 Check 1: if prng_o==start_val and scnt==2^N, period_ok SHALL set.
REQ-022 Check 2: if prng_o==start_val and scnt<2^N, period_err SHALL set.
REQ-023 Check 3: if scnt==2^N and prng_o!=start_val, period_err SHALL set.
REQ-024 period_ok and period_err SHALL be mutually exclusive and SHALL remain set until reset; the flags SHALL NOT affect grants.
REQ-025 req bits that change mid-cycle SHALL affect only prng_en combinationally; the grant decision SHALL use req as sampled at the posedge.

Reset
REQ-026 While rst_n=0: gnt=0, rnd=0, rnd_vld=0, prng_en=0, period_ok=0, period_err=0, scnt=0, start_val=0, last_granted=NREQ-1, state=S_INIT, immediately and independent of ck.
REQ-027 Asserting reset mid-operation SHALL discard any in-flight grant and the period check; after release, the block SHALL re-capture start_val in S_INIT.

Structure
REQ-028 The shared package/include nlprg_pkg SHALL hold the FSM state encodings (S_INIT, S_RUN) and the default N and NREQ.
REQ-029 Round-robin selection SHALL live in sub-module nlprg_rr_arb (inputs req and last_granted; output one-hot winner), purely combinational.
REQ-030 Total RTL SHALL be about 150-250 lines; no memories.

Verification (stub PRNG = 4-bit up-counter, reset value 0, steps on prng_en)
REQ-031 Reset: hold rst_n=0 with req=4'b1111 -> gnt=0, rnd_vld=0, prng_en=0, flags=0; first cycle after release, prng_en=0 (S_INIT).
REQ-032 Single requester: req=4'b0001 held 3 cycles in S_RUN -> gnt=0001 for 3 cycles, rnd=0,1,2, then gnt=0 one cycle after req drops.
REQ-033 Round-robin: req=4'b1111 held -> gnt=0001,0010,0100,1000,0001; with req=4'b0101 -> gnt alternates 0001/0100.
REQ-034 Full period: req=4'b0001 held for 16 grants -> period_ok=1 the cycle after the 16th step (prng_o back to 0), period_err=0.
REQ-035 Short period: stub wraps modulo 8 -> period_err=1 after the 8th step, period_ok stays 0.
REQ-036 Mid-op reset: pulse rst_n low after 5 grants -> all outputs 0 asynchronously; after release, start_val is re-captured and a 16-step run gives period_ok=1.
